// File: rtl/rgb2yuv_pkg.sv
// rgb2yuv_pkg: shared constants, FSM state encoding and small helpers for the
// RGB888 -> YUV 4:2:2 downsampler.
//  - Colour-space coefficients (8-bit fixed point, scaled by 256)
//  - Rounding constant and chroma offset
//  - Words read / written per 4-pixel group
//  - clip8: clamp a signed intermediate to 0..255
//  - avg8:  rounded mean of two 8-bit samples (chroma averaging build)
package rgb2yuv_pkg;

  localparam logic signed [17:0] C_YR =  18'sd77;
  localparam logic signed [17:0] C_YG =  18'sd150;
  localparam logic signed [17:0] C_YB =  18'sd29;
  localparam logic signed [17:0] C_UR = -18'sd43;
  localparam logic signed [17:0] C_UG = -18'sd85;
  localparam logic signed [17:0] C_UB =  18'sd128;
  localparam logic signed [17:0] C_VR =  18'sd128;
  localparam logic signed [17:0] C_VG = -18'sd107;
  localparam logic signed [17:0] C_VB = -18'sd21;

  localparam logic signed [17:0] ROUND_K    = 18'sd128;
  localparam logic signed [17:0] CHROMA_OFS = 18'sd128;

  localparam int unsigned RD_WORDS = 6;
  localparam int unsigned WR_WORDS = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_LAST,
    S_CALC,
    S_WR,
    S_DONE
  } state_t;

  function automatic logic [7:0] clip8(input logic signed [17:0] v);
    if (v < 18'sd0)
      return 8'd0;
    else if (v > 18'sd255)
      return 8'd255;
    else
      return v[7:0];
  endfunction

  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

endpackage

// File: rtl/rgb2yuv_pixel_calc.sv
// rgb2yuv_pixel_calc: combinational conversion of one RGB888 pixel to clipped
// 8-bit Y, U, V using signed 18-bit intermediates and arithmetic shifts.
// Ports:
//  r, g, b  in   8  pixel components
//  y, u, v  out  8  converted components, each clamped to 0..255
module rgb2yuv_pixel_calc
  import rgb2yuv_pkg::*;
(
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] y,
  output logic [7:0] u,
  output logic [7:0] v
);

  logic signed [17:0] rs, gs, bs;
  logic signed [17:0] y_acc, u_acc, v_acc;

  assign rs = $signed({10'd0, r});
  assign gs = $signed({10'd0, g});
  assign bs = $signed({10'd0, b});

  assign y_acc = (C_YR * rs + C_YG * gs + C_YB * bs + ROUND_K) >>> 8;
  assign u_acc = ((C_UR * rs + C_UG * gs + C_UB * bs + ROUND_K) >>> 8) + CHROMA_OFS;
  assign v_acc = ((C_VR * rs + C_VG * gs + C_VB * bs + ROUND_K) >>> 8) + CHROMA_OFS;

  assign y = clip8(y_acc);
  assign u = clip8(u_acc);
  assign v = clip8(v_acc);

endmodule

// File: rtl/rgb_to_yuv_downsampler.sv
// rgb_to_yuv_downsampler: reads a packed RGB888 frame from SRAM, converts to
// YUV and writes planar Y, U, V with 2:1 horizontal chroma decimation (4:2:2).
// Each 4-pixel group takes 12 cycles: 6 reads, 1 capture, 1 calc, 4 writes.
// Build option: RGB2YUV_CHROMA_AVG_EN -- when defined, chroma of each pixel
// pair is computed from the rounded average of the two pixels; otherwise the
// even pixel alone is used.
// Ports:
//  clk        in   1   clock
//  reset      in   1   asynchronous active-high reset
//  start      in   1   one-cycle pulse, starts a frame when idle
//  done       out  1   one-cycle pulse after the last V word is written
//  raddr      out  AW  SRAM read address (data returns next cycle)
//  rdata      in   DW  SRAM read data
//  waddr      out  AW  SRAM write address
//  wdata      out  DW  SRAM write data
//  wr_enable  out  1   SRAM write strobe
module rgb_to_yuv_downsampler
  import rgb2yuv_pkg::*;
#(
  parameter int unsigned AW              = 18,
  parameter int unsigned DW              = 16,
  parameter int unsigned W               = 320,
  parameter int unsigned H               = 240,
  parameter int unsigned READ_ADDR_BASE  = 115200,
  parameter int unsigned WRITE_ADDR_BASE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          wr_enable
);

  localparam int unsigned GROUPS = W * H / 4;
  localparam int unsigned GW     = $clog2(GROUPS + 1);
  localparam int unsigned U_BASE = WRITE_ADDR_BASE + W * H / 2;
  localparam int unsigned V_BASE = U_BASE + W * H / 4;

  localparam logic [AW-1:0] R_BASE_A = AW'(READ_ADDR_BASE);
  localparam logic [AW-1:0] Y_BASE_A = AW'(WRITE_ADDR_BASE);
  localparam logic [AW-1:0] U_BASE_A = AW'(U_BASE);
  localparam logic [AW-1:0] V_BASE_A = AW'(V_BASE);
  localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);
  localparam logic [2:0]    LAST_RD  = 3'(RD_WORDS - 1);
  localparam logic [1:0]    LAST_WR  = 2'(WR_WORDS - 1);

  state_t        state;
  logic [GW-1:0] grp;
  logic [2:0]    rd_k;
  logic [1:0]    wr_k;
  logic [DW-1:0] word_q [RD_WORDS];

  logic [7:0] pr [4];
  logic [7:0] pg [4];
  logic [7:0] pb [4];
  logic [7:0] y_c [4];
  logic [7:0] u_c [2];
  logic [7:0] v_c [2];
  logic [7:0] cr [2];
  logic [7:0] cg [2];
  logic [7:0] cb [2];

  logic [7:0] y_q [4];
  logic [7:0] u01_q, u23_q, v01_q, v23_q;

  logic [7:0] unused_u [4];
  logic [7:0] unused_v [4];
  logic [7:0] unused_cy [2];

  logic [AW-1:0] grp_a;
  logic [AW-1:0] nxt_addr;
  logic [DW-1:0] nxt_data;

  // Unpack {R0,G0} {B0,R1} {G1,B1} per pixel pair; pair h uses words 3h..3h+2.
  always_comb begin
    for (int unsigned h = 0; h < 2; h++) begin
      pr[2*h]   = word_q[3*h][15:8];
      pg[2*h]   = word_q[3*h][7:0];
      pb[2*h]   = word_q[3*h+1][15:8];
      pr[2*h+1] = word_q[3*h+1][7:0];
      pg[2*h+1] = word_q[3*h+2][15:8];
      pb[2*h+1] = word_q[3*h+2][7:0];
    end
  end

  always_comb begin
    for (int unsigned h = 0; h < 2; h++) begin
`ifdef RGB2YUV_CHROMA_AVG_EN
      cr[h] = avg8(pr[2*h], pr[2*h+1]);
      cg[h] = avg8(pg[2*h], pg[2*h+1]);
      cb[h] = avg8(pb[2*h], pb[2*h+1]);
`else
      cr[h] = pr[2*h];
      cg[h] = pg[2*h];
      cb[h] = pb[2*h];
`endif
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_luma
    rgb2yuv_pixel_calc u_luma (
      .r (pr[i]),
      .g (pg[i]),
      .b (pb[i]),
      .y (y_c[i]),
      .u (unused_u[i]),
      .v (unused_v[i])
    );
  end

  for (genvar h = 0; h < 2; h++) begin : g_chroma
    rgb2yuv_pixel_calc u_chroma (
      .r (cr[h]),
      .g (cg[h]),
      .b (cb[h]),
      .y (unused_cy[h]),
      .u (u_c[h]),
      .v (v_c[h])
    );
  end

  assign grp_a = AW'(grp);

  // Word to present after write slot wr_k; slot 0 is loaded straight from the
  // combinational results on the CALC edge.
  always_comb begin
    nxt_addr = Y_BASE_A + (grp_a << 1) + AW'(1);
    nxt_data = {y_q[2], y_q[3]};
    unique case (wr_k)
      2'd0: begin
        nxt_addr = Y_BASE_A + (grp_a << 1) + AW'(1);
        nxt_data = {y_q[2], y_q[3]};
      end
      2'd1: begin
        nxt_addr = U_BASE_A + grp_a;
        nxt_data = {u01_q, u23_q};
      end
      default: begin
        nxt_addr = V_BASE_A + grp_a;
        nxt_data = {v01_q, v23_q};
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      grp       <= '0;
      rd_k      <= '0;
      wr_k      <= '0;
      raddr     <= '0;
      waddr     <= '0;
      wdata     <= '0;
      wr_enable <= 1'b0;
      done      <= 1'b0;
      u01_q     <= '0;
      u23_q     <= '0;
      v01_q     <= '0;
      v23_q     <= '0;
      for (int unsigned i = 0; i < RD_WORDS; i++) word_q[i] <= '0;
      for (int unsigned i = 0; i < 4; i++) y_q[i] <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RD;
            grp   <= '0;
            rd_k  <= '0;
            raddr <= R_BASE_A;
          end
        end
        S_RD: begin
          // rdata returned now belongs to the address issued last cycle.
          if (rd_k != 3'd0) word_q[rd_k - 3'd1] <= rdata;
          if (rd_k == LAST_RD) begin
            state <= S_RD_LAST;
          end else begin
            rd_k  <= rd_k + 3'd1;
            raddr <= raddr + AW'(1);
          end
        end
        S_RD_LAST: begin
          word_q[RD_WORDS-1] <= rdata;
          state <= S_CALC;
        end
        S_CALC: begin
          for (int unsigned i = 0; i < 4; i++) y_q[i] <= y_c[i];
          u01_q     <= u_c[0];
          u23_q     <= u_c[1];
          v01_q     <= v_c[0];
          v23_q     <= v_c[1];
          waddr     <= Y_BASE_A + (grp_a << 1);
          wdata     <= {y_c[0], y_c[1]};
          wr_enable <= 1'b1;
          wr_k      <= '0;
          state     <= S_WR;
        end
        S_WR: begin
          if (wr_k == LAST_WR) begin
            wr_enable <= 1'b0;
            if (grp == LAST_GRP) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              // raddr sits on word 5 of this group, so +1 is word 0 of the next.
              grp   <= grp + GW'(1);
              raddr <= raddr + AW'(1);
              rd_k  <= '0;
              state <= S_RD;
            end
          end else begin
            wr_k  <= wr_k + 2'd1;
            waddr <= nxt_addr;
            wdata <= nxt_data;
          end
        end
        S_DONE: begin
          grp   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
